// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution window generator.
// Pixel width and kernel edge are fixed here because pixel_t and N_TAPS depend on them.
package conv_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int K          = 3;
  localparam int N_TAPS     = K * K;

  typedef logic signed [DATA_WIDTH-1:0] pixel_t;

  // A counter over n positions needs at least one bit, even when n == 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of pixel storage.
// rd_data shows the entry currently at addr, which is the value being replaced by a write at that address.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        wr_en,
  input  logic [cnt_width(DEPTH)-1:0] addr,
  input  pixel_t                      wr_data,
  output pixel_t                      rd_data
);

  pixel_t mem_q [DEPTH];

  assign rd_data = mem_q[addr];

  // NOTE: storage is deliberately left out of reset. Stale rows are never
  // exposed because window output is gated by the row counter, and leaving
  // the RAM unreset lets it map onto plain memory cells.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// KxK sliding-window generator feeding the convolution adder tree, built on K-1 cascaded line buffers.
// Define CONV_WIN_STALL_CNT_EN to add the stall_cnt backpressure counter port.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   in_valid,
  output logic   in_ready,
  input  pixel_t in_data,
  output logic   out_valid,
  input  logic   out_ready,
  output pixel_t out_window [N_TAPS],
  output logic   out_last
`ifdef CONV_WIN_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam int CW = cnt_width(IMG_W);
  localparam int RW = cnt_width(IMG_H);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_WIN  = CW'(K - 1);
  localparam logic [RW-1:0] ROW_WIN  = RW'(K - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;

  pixel_t win_q      [K][K];
  pixel_t win_d      [K][K];
  pixel_t win_flat   [N_TAPS];
  pixel_t out_win_q  [N_TAPS];

  pixel_t lb_wr  [K-1];
  pixel_t lb_rd  [K-1];
  pixel_t tap_in [K];

  logic in_xfer;
  logic win_done;
  logic frame_end;

  assign in_ready  = !out_valid_q || out_ready;
  assign in_xfer   = in_valid && in_ready;
  assign win_done  = in_xfer && (row_q >= ROW_WIN) && (col_q >= COL_WIN);
  assign frame_end = (row_q == ROW_LAST) && (col_q == COL_LAST);

  // Cascade: each buffer takes the entry its upstream neighbour is overwriting.
  for (genvar i = 0; i < K - 1; i++) begin : g_lb
    if (i == 0) begin : g_head
      assign lb_wr[i] = in_data;
    end else begin : g_tail
      assign lb_wr[i] = lb_rd[i-1];
    end

    conv_line_buffer #(
      .DEPTH (IMG_W)
    ) u_line_buffer (
      .clk     (clk),
      .wr_en   (in_xfer),
      .addr    (col_q),
      .wr_data (lb_wr[i]),
      .rd_data (lb_rd[i])
    );
  end

  // Window row r takes image row (row-K+1+r); buffer i holds image row (row-1-i).
  for (genvar r = 0; r < K - 1; r++) begin : g_tap
    assign tap_in[r] = lb_rd[K-2-r];
  end
  assign tap_in[K-1] = in_data;

  always_comb begin
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        win_d[r][c] = win_q[r][c+1];
      end
      win_d[r][K-1] = tap_in[r];
    end
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        win_flat[r*K+c] = win_d[r][c];
      end
    end
  end

  // NOTE: every combinational output takes a default before any branch, so
  // no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    if (in_xfer) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    if (win_done) begin
      out_valid_d = 1'b1;
      out_last_d  = frame_end;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_q[r][c] <= '0;
        end
      end
      for (int t = 0; t < N_TAPS; t++) begin
        out_win_q[t] <= '0;
      end
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      if (in_xfer) begin
        win_q <= win_d;
      end
      if (win_done) begin
        out_win_q <= win_flat;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign out_window = out_win_q;

`ifdef CONV_WIN_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (out_valid_q && !out_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen on a 4x4 image with a 3x3 kernel.
// Expected windows are derived from the driven frames and checked as the DUT emits them.
module tb_conv_window_gen;
  import conv_pkg::*;

  localparam int IW = 4;
  localparam int IH = 4;
  localparam int NPIX = IW * IH;

  typedef pixel_t frame_t [NPIX];
  typedef struct packed {
    logic                             last;
    logic [N_TAPS-1:0][DATA_WIDTH-1:0] taps;
  } win_t;

  logic   clk = 1'b0;
  logic   rst_n;
  logic   in_valid;
  logic   in_ready;
  pixel_t in_data;
  logic   out_valid;
  logic   out_ready;
  pixel_t out_window [N_TAPS];
  logic   out_last;
`ifdef CONV_WIN_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  win_t exp_q [$];
  win_t last_obs;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_win    = 0;
  bit   rand_mode = 1'b0;

  always #5 clk = ~clk;

  conv_window_gen #(
    .IMG_W (IW),
    .IMG_H (IH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_window (out_window),
    .out_last   (out_last)
`ifdef CONV_WIN_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic win_t obs_win();
    win_t w;
    for (int i = 0; i < N_TAPS; i++) w.taps[i] = out_window[i];
    w.last = out_last;
    return w;
  endfunction

  function automatic frame_t seq_frame(input int base);
    frame_t f;
    for (int i = 0; i < NPIX; i++) f[i] = pixel_t'(base + i);
    return f;
  endfunction

  // Reference model: one window per valid kernel position, oldest row first.
  task automatic expect_frame(input frame_t pix);
    win_t w;
    for (int row = K - 1; row < IH; row++) begin
      for (int col = K - 1; col < IW; col++) begin
        w.last = (row == IH - 1) && (col == IW - 1);
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++)
            w.taps[r*K+c] = pix[(row - K + 1 + r) * IW + (col - K + 1 + c)];
        exp_q.push_back(w);
      end
    end
  endtask

  // Drive one pixel; returns at #1 after the edge that accepted it.
  task automatic send(input pixel_t v);
    int  budget;
    bit  acc;
    budget = 200;
    if (rand_mode) begin
      while ($urandom_range(0, 1) == 1) begin
        in_valid  = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1;
    in_data  = v;
    acc      = 1'b0;
    while (!acc && budget > 0) begin
      if (rand_mode) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      budget--;
    end
    if (!acc) check("send_timeout", 160'(acc), 160'(1));
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input frame_t pix);
    for (int i = 0; i < NPIX; i++) send(pix[i]);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    frame_t f1, f2, fr;
    win_t   held;
    int     w0, s;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    fork
      forever begin
        win_t obs;
        @(negedge clk);
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
          obs = obs_win();
          n_win++;
          check("sb_has_entry", 160'(exp_q.size() > 0), 160'(1));
          if (exp_q.size() > 0) check("window", 160'(obs), 160'(exp_q.pop_front()));
          last_obs = obs;
        end
      end
    join_none

    // Reset state
    #1;
    check("rst_out_valid", 160'(out_valid), 160'(0));
    check("rst_out_last", 160'(out_last), 160'(0));
    check("rst_in_ready", 160'(in_ready), 160'(1));
    check("rst_window", 160'(obs_win()), 160'(0));
`ifdef CONV_WIN_STALL_CNT_EN
    check("rst_stall_cnt", 160'(stall_cnt), 160'(0));
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single frame, no backpressure
    f1 = seq_frame(1);
    expect_frame(f1);
    w0 = n_win;
    for (int i = 0; i < 10; i++) send(f1[i]);
    check("no_early_window", 160'(out_valid), 160'(0));
    send(f1[10]);
    check("first_latency", 160'(out_valid), 160'(1));
    for (int i = 11; i < NPIX; i++) send(f1[i]);
    idle(4);
    check("s1_count", 160'(n_win - w0), 160'(4));
    s = 0;
    for (int i = 0; i < N_TAPS; i++) s += int'(last_obs.taps[i]);
    check("s1_tap_sum", 160'(s), 160'(99));
    check("s1_last_flag", 160'(last_obs.last), 160'(1));
    check("s1_idle_valid", 160'(out_valid), 160'(0));

    // Backpressure on the first window
    expect_frame(f1);
    w0 = n_win;
    out_ready = 1'b0;
    for (int i = 0; i < 11; i++) send(f1[i]);
    held = exp_q[0];
    in_valid = 1'b1;
    in_data  = f1[11];
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", 160'(in_ready), 160'(0));
      check("bp_out_valid", 160'(out_valid), 160'(1));
      check("bp_hold", 160'(obs_win()), 160'(held));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int i = 11; i < NPIX; i++) send(f1[i]);
`ifdef CONV_WIN_STALL_CNT_EN
    check("stall_cnt", 160'(stall_cnt), 160'(5));
`endif
    idle(4);
    check("bp_count", 160'(n_win - w0), 160'(4));

    // Back-to-back frames
    f2 = seq_frame(101);
    expect_frame(f1);
    expect_frame(f2);
    w0 = n_win;
    send_frame(f1);
    send_frame(f2);
    idle(4);
    check("b2b_count", 160'(n_win - w0), 160'(8));
    check("b2b_sb_empty", 160'(exp_q.size()), 160'(0));

    // Reset in the middle of a frame
    for (int i = 0; i < 7; i++) send(f1[i]);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 160'(out_valid), 160'(0));
    check("midrst_in_ready", 160'(in_ready), 160'(1));
`ifdef CONV_WIN_STALL_CNT_EN
    check("midrst_stall_cnt", 160'(stall_cnt), 160'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    expect_frame(f1);
    w0 = n_win;
    send_frame(f1);
    idle(4);
    check("midrst_count", 160'(n_win - w0), 160'(4));
    check("midrst_sb_empty", 160'(exp_q.size()), 160'(0));

    // Random valid/ready over three frames
    rand_mode = 1'b1;
    w0 = n_win;
    for (int fcount = 0; fcount < 3; fcount++) begin
      for (int i = 0; i < NPIX; i++) fr[i] = pixel_t'($urandom);
      expect_frame(fr);
      send_frame(fr);
    end
    begin
      int budget;
      budget = 500;
      while (exp_q.size() > 0 && budget > 0) begin
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        budget--;
      end
    end
    rand_mode = 1'b0;
    out_ready = 1'b1;
    idle(4);
    check("rand_sb_empty", 160'(exp_q.size()), 160'(0));
    check("rand_count", 160'(n_win - w0), 160'(12));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
